mu_error_gen: RTL and testbench
===============================

Name: mu_error_gen

Overview:
- Upstream feeder for the per-tap weight-update stage of the adaptive filter.
- Computes the instantaneous error e = d - y and scales it by a scheduled step size mu, producing mu_error.
- Re-times the regressor sample so mu_error and x_n reach the weight-update stage on the same cycle.
- Step size follows a warm-up/track schedule (fast mu first, then slow mu), with freeze and restart control.

Parameters:
- WIDTH, 16: data width, two's complement fixed point.
- QP, 12: fractional bits (Q(WIDTH-QP).QP).
- MU_FAST, 16'h0200: warm-up step size, 0.125 in Q4.12.
- MU_SLOW, 16'h0040: tracking step size, 1/64 in Q4.12.
- WARMUP_LEN, 256: number of accepted samples spent in WARMUP; range 1 to 2^CNT_W-1.
- CNT_W, 16: warm-up counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  d_n, y_n and x_n_in are valid this cycle.
- d_n  in  WIDTH  desired signal sample.
- y_n  in  WIDTH  filter output sample.
- x_n_in  in  WIDTH  regressor sample belonging to this error.
- adapt_en  in  1  level; 0 freezes adaptation.
- restart  in  1  one-cycle pulse; restarts the schedule.
- out_valid  out  1  mu_error and x_n are valid.
- mu_error  out  WIDTH  round(mu*e), saturated.
- x_n  out  WIDTH  x_n_in delayed to align with mu_error.
- error  out  WIDTH  unscaled saturated e, for monitoring, aligned with mu_error.
- state  out  2  FSM state: 00 IDLE, 01 WARMUP, 10 TRACK, 11 HOLD.

Behaviour:
Reset:
- reset=0 asynchronously clears all registers.
- Outputs after reset: out_valid=0, mu_error=0, error=0, x_n=0, state=IDLE. Warm-up counter=0; resume register=WARMUP.

Pipeline:
- Latency is 2 cycles from in_valid to out_valid. No backpressure; one sample per cycle is sustained.
- Stage 1 registers:
  - e = sat(d_n - y_n), computed in WIDTH+1 bits and clamped to [0x8000, 0x7FFF].
  - mu_sel, taken from the current state at acceptance: IDLE 0, WARMUP MU_FAST, TRACK MU_SLOW, HOLD 0.
  - x_n_in and in_valid.
- Stage 2 computes p = e*mu_sel as a 2*WIDTH signed product, adds 1<<(QP-1), takes bits [QP +: WIDTH].
  - If the discarded upper bits are not a sign extension, saturate to 0x7FFF or 0x8000.
- The weight-update stage accumulates every clock. So on cycles where out_valid=0, mu_error is forced to 0 and x_n holds its last value.
- The error output holds its last value while out_valid=0.

FSM (advances only on edges where in_valid=1, except for restart):
- IDLE -> WARMUP when in_valid and adapt_en. The triggering sample uses mu=0 and is not counted.
- WARMUP:
  - Each accepted sample increments the counter.
  - When the counter reaches WARMUP_LEN-1 and in_valid=1, go to TRACK and clear the counter; that sample still uses MU_FAST.
  - If adapt_en=0 while in_valid=1: save WARMUP as the resume state, go to HOLD. The counter is frozen and that sample uses mu=0.
- TRACK: if adapt_en=0 while in_valid=1, save TRACK as the resume state and go to HOLD.
- HOLD:
  - Samples pass through with mu=0 and out_valid still asserted.
  - If adapt_en=1 while in_valid=1, return to the resume state; that sample uses the resume state's mu.

Boundary rules:
- restart=1 has priority over every transition. Next state is IDLE, the counter clears and the resume state becomes WARMUP.
- On a restart edge, the sample accepted in the same cycle uses mu of the current state.
- Samples already in the pipeline complete unchanged.
- WARMUP_LEN=1: a single WARMUP sample, then TRACK.
- Only reset clears the pipeline; restart does not.

Test Plan:
- Reset, then warm-up: assert reset=0 mid-stream -> outputs and state are zero/IDLE immediately. Release, adapt_en=1, in_valid pulses with d=0x1000, y=0x0800 -> first sample gives mu_error=0 at cycle+2; the next gives state=01, mu_error=0x0100, error=0x0800, x_n equal to x_n_in from 2 cycles earlier.
- Schedule transition: WARMUP_LEN=4, continuous valid with e=0x0800 -> four samples give mu_error=0x0100, then TRACK with mu_error=0x0020 (0.5/64).
- Saturation: d=0x7FFF, y=0x8000 -> error=0x7FFF. MU_FAST=0x7FFF -> mu_error=0x7FFF. d=0x8000, y=0x7FFF -> error=0x8000.
- Freeze/resume: in TRACK drop adapt_en for 3 valid samples -> state=11, mu_error=0 with out_valid=1. Raise adapt_en -> back to TRACK with mu_error=0x0020.
- Gaps and restart: in_valid toggling 1/0 -> mu_error=0 on invalid output cycles and x_n held. Pulse restart in TRACK -> state=IDLE next cycle, in-flight outputs unchanged, and a full warm-up repeats.

Source files
------------

// File: rtl/mu_error_gen.sv
// Error/step-size feeder for the adaptive filter's weight-update stage.
// Produces round(mu*(d-y)) two cycles after acceptance, with a warm-up/track mu schedule.
module mu_error_gen #(
    parameter int unsigned            WIDTH      = 16,
    parameter int unsigned            QP         = 12,
    parameter logic [WIDTH-1:0]       MU_FAST    = 16'h0200,
    parameter logic [WIDTH-1:0]       MU_SLOW    = 16'h0040,
    parameter int unsigned            WARMUP_LEN = 256,
    parameter int unsigned            CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d_n,
    input  logic [WIDTH-1:0] y_n,
    input  logic [WIDTH-1:0] x_n_in,
    input  logic             adapt_en,
    input  logic             restart,
    output logic             out_valid,
    output logic [WIDTH-1:0] mu_error,
    output logic [WIDTH-1:0] x_n,
    output logic [WIDTH-1:0] error,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WARMUP = 2'b01,
        TRACK  = 2'b10,
        HOLD   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_LEN - 1);
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] RND    = (2*WIDTH)'(1) << (QP - 1);

    state_t           cur, nxt, resume, resume_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] mu_sel;

    function automatic logic [WIDTH-1:0] mu_of(input state_t s);
        case (s)
            WARMUP:  return MU_FAST;
            TRACK:   return MU_SLOW;
            default: return '0;
        endcase
    endfunction

    assign state = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur    <= IDLE;
            resume <= WARMUP;
            cnt    <= '0;
        end else begin
            cur    <= nxt;
            resume <= resume_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // mu_sel is the step size applied to the sample accepted this cycle, so it
    // already reflects the freeze/resume decision taken on the same edge.
    always_comb begin
        nxt        = cur;
        resume_nxt = resume;
        cnt_nxt    = cnt;
        mu_sel     = mu_of(cur);
        if (restart) begin
            nxt        = IDLE;
            cnt_nxt    = '0;
            resume_nxt = WARMUP;
        end else if (in_valid) begin
            case (cur)
                IDLE: begin
                    if (adapt_en) nxt = WARMUP;
                end
                WARMUP: begin
                    if (!adapt_en) begin
                        mu_sel     = '0;
                        resume_nxt = WARMUP;
                        nxt        = HOLD;
                    end else if (cnt == CNT_LAST) begin
                        nxt     = TRACK;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                TRACK: begin
                    if (!adapt_en) begin
                        mu_sel     = '0;
                        resume_nxt = TRACK;
                        nxt        = HOLD;
                    end
                end
                HOLD: begin
                    if (adapt_en) begin
                        nxt    = resume;
                        mu_sel = mu_of(resume);
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    logic [WIDTH:0]          diff;
    logic [WIDTH-1:0]        e_sat;
    logic signed [WIDTH-1:0] e1, mu1;
    logic [WIDTH-1:0]        x1;
    logic                    v1;

    assign diff  = {d_n[WIDTH-1], d_n} - {y_n[WIDTH-1], y_n};
    assign e_sat = (diff[WIDTH] != diff[WIDTH-1]) ? (diff[WIDTH] ? SAT_MIN : SAT_MAX)
                                                 : diff[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e1  <= '0;
            mu1 <= '0;
            x1  <= '0;
            v1  <= 1'b0;
        end else begin
            e1  <= e_sat;
            mu1 <= mu_sel;
            x1  <= x_n_in;
            v1  <= in_valid;
        end
    end

    logic signed [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]          prod_r;
    logic [WIDTH-QP:0]           upper;
    logic [WIDTH-1:0]            scaled;
    logic                        rnd_unused;

    assign prod       = e1 * mu1;
    assign prod_r     = prod + RND;
    assign upper      = prod_r[2*WIDTH-1:QP+WIDTH-1];
    assign rnd_unused = ^prod_r[QP-1:0];
    assign scaled     = ((upper == '0) || (upper == '1)) ? prod_r[QP +: WIDTH]
                      : (prod_r[2*WIDTH-1] ? SAT_MIN : SAT_MAX);

    // Downstream accumulates every clock, so mu_error must be zero on idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            mu_error  <= '0;
            x_n       <= '0;
            error     <= '0;
        end else begin
            out_valid <= v1;
            mu_error  <= v1 ? scaled : '0;
            if (v1) begin
                x_n   <= x1;
                error <= e1;
            end
        end
    end

endmodule

// File: tb/tb_mu_error_gen.sv
// Bench for mu_error_gen: directed scenarios plus random traffic against a
// schedule-level reference model; a second instance uses a full-scale MU_FAST.
module tb_mu_error_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, adapt_en = 1'b0, restart = 1'b0;
    logic [15:0] d_n = '0, y_n = '0, x_n_in = '0;

    logic        ov, ov_s;
    logic [15:0] mue, mue_s, xo, xo_s, err, err_s;
    logic [1:0]  st, st_s;

    mu_error_gen #(.WIDTH(16), .QP(12), .MU_FAST(16'h0200), .MU_SLOW(16'h0040),
                   .WARMUP_LEN(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .d_n(d_n), .y_n(y_n),
        .x_n_in(x_n_in), .adapt_en(adapt_en), .restart(restart),
        .out_valid(ov), .mu_error(mue), .x_n(xo), .error(err), .state(st));

    mu_error_gen #(.WIDTH(16), .QP(12), .MU_FAST(16'h7FFF), .MU_SLOW(16'h0040),
                   .WARMUP_LEN(4), .CNT_W(16)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .d_n(d_n), .y_n(y_n),
        .x_n_in(x_n_in), .adapt_en(adapt_en), .restart(restart),
        .out_valid(ov_s), .mu_error(mue_s), .x_n(xo_s), .error(err_s), .state(st_s));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phases use the externally visible state codes.
    localparam int P_IDLE = 0, P_WARM = 1, P_TRACK = 2, P_HOLD = 3;
    localparam int WLEN = 4;
    int m_phase, m_cnt, m_resume;
    int m1_v, m1_e, m1_r, m1_rs, m1_x;
    int exp_ov, exp_mue, exp_mues, exp_err, exp_x;

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int mu_val(input int phase, input int fast);
        if (phase == P_WARM) return fast;
        if (phase == P_TRACK) return 'h40;
        return 0;
    endfunction

    function automatic int scale(input int e, input int mu);
        longint p;
        p = longint'(e) * longint'(mu) + 2048;
        return sat16(p >>> 12);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_cnt = 0; m_resume = P_WARM;
        m1_v = 0; m1_e = 0; m1_r = 0; m1_rs = 0; m1_x = 0;
        exp_ov = 0; exp_mue = 0; exp_mues = 0; exp_err = 0; exp_x = 0;
    endtask

    task automatic model_edge();
        int rate_phase, e;
        exp_ov = m1_v;
        if (m1_v != 0) begin
            exp_mue = m1_r; exp_mues = m1_rs; exp_err = m1_e; exp_x = m1_x;
        end else begin
            exp_mue = 0; exp_mues = 0;
        end
        rate_phase = m_phase;
        if (restart) begin
            m_phase = P_IDLE; m_cnt = 0; m_resume = P_WARM;
        end else if (in_valid) begin
            if (m_phase == P_IDLE) begin
                if (adapt_en) m_phase = P_WARM;
            end else if (m_phase == P_HOLD) begin
                if (adapt_en) begin
                    rate_phase = m_resume;
                    m_phase = m_resume;
                end
            end else if (!adapt_en) begin
                rate_phase = P_IDLE;
                m_resume = m_phase;
                m_phase = P_HOLD;
            end else if (m_phase == P_WARM) begin
                m_cnt++;
                if (m_cnt == WLEN) begin
                    m_phase = P_TRACK; m_cnt = 0;
                end
            end
        end
        e = sat16(longint'($signed(d_n)) - longint'($signed(y_n)));
        m1_v  = in_valid ? 1 : 0;
        m1_e  = e;
        m1_x  = int'(x_n_in);
        m1_r  = scale(e, mu_val(rate_phase, 'h0200));
        m1_rs = scale(e, mu_val(rate_phase, 'h7FFF));
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input int exp);
        logic [15:0] e16;
        e16 = exp[15:0];
        tests++;
        assert (obs === e16) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, e16, $time);
        end
    endtask

    task automatic check_all();
        chk("state", {14'b0, st}, m_phase);
        chk("out_valid", {15'b0, ov}, exp_ov);
        chk("mu_error", mue, exp_mue);
        chk("error", err, exp_err);
        chk("x_n", xo, exp_x);
        chk("mu_error_sat", mue_s, exp_mues);
        chk("out_valid_sat", {15'b0, ov_s}, exp_ov);
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic [15:0] y,
                        input logic [15:0] x, input logic a, input logic r);
        in_valid = v; d_n = d; y_n = y; x_n_in = x; adapt_en = a; restart = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) reset = 1'b1;

        // Traffic, then an asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 6; i++) step(1'b1, 16'h1000, 16'h0800, 16'(i + 16'h50), 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk) reset = 1'b1;

        // Warm-up with in_valid pulsing 1/0, into TRACK.
        for (int i = 0; i < 14; i++)
            step(i % 2 == 0, 16'h1000, 16'h0800, 16'(16'hA000 + i), 1'b1, 1'b0);
        // Continuous valid, e = 0.5.
        for (int i = 0; i < 6; i++) step(1'b1, 16'h0C00, 16'h0400, 16'(16'hB000 + i), 1'b1, 1'b0);

        // Freeze in TRACK for 3 samples, then resume.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h1000, 16'h0800, 16'(16'hC000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h1000, 16'h0800, 16'(16'hC100 + i), 1'b1, 1'b0);

        // Restart in TRACK with the pipeline full; saturating errors during the new warm-up.
        step(1'b1, 16'h1000, 16'h0800, 16'hD000, 1'b1, 1'b1);
        step(1'b1, 16'h1000, 16'h0800, 16'hD001, 1'b1, 1'b0);
        step(1'b1, 16'h7FFF, 16'h8000, 16'hD002, 1'b1, 1'b0);
        step(1'b1, 16'h8000, 16'h7FFF, 16'hD003, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 16'hD004, 1'b1, 1'b0);
        step(1'b1, 16'h7FFF, 16'h8000, 16'hD005, 1'b0, 1'b0);
        step(1'b1, 16'h7FFF, 16'h8000, 16'hD006, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 16'h8000, 16'h0001, 16'(16'hD100 + i), 1'b1, 1'b0);

        // Randomized traffic including freezes, gaps and restarts.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] d, y;
            d = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                d = 16'h7FFF; y = 16'h8000 + 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) begin
                d = 16'h8000; y = 16'h7FFF - 16'($urandom_range(0, 3));
            end
            step($urandom_range(0, 3) != 0, d, y, 16'($urandom),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
